// File: rtl/pc_gen_if.sv
// Fetch-PC handshake, redirect and status bundle between pc_gen and the IFU/EXU side.
interface pc_gen_if #(
  parameter int BITWIDTH = 32
);
  // fetch handshake
  logic                pc_valid;
  logic                pc_ready;
  logic [BITWIDTH-1:0] pc;
  // branch/jump redirect
  logic                redir_valid;
  logic [BITWIDTH-1:0] redir_pc;
  logic                redir_sel;
  logic [BITWIDTH-1:0] rs1_data;
  logic [31:0]         imm;
  // exception/mret redirect
  logic                exc_valid;
  logic [BITWIDTH-1:0] exc_target;
  // status
  logic                misalign;
  logic [BITWIDTH-1:0] bad_target;
  logic [BITWIDTH-1:0] fetch_cnt;

  modport master (
    output pc, pc_valid, misalign, bad_target, fetch_cnt,
    input  pc_ready, redir_valid, redir_pc, redir_sel, rs1_data, imm,
           exc_valid, exc_target
  );

  modport slave (
    input  pc, pc_valid, misalign, bad_target, fetch_cnt,
    output pc_ready, redir_valid, redir_pc, redir_sel, rs1_data, imm,
           exc_valid, exc_target
  );
endinterface

// File: rtl/pc_gen.sv
// Fetch program-counter generator: sequential advance on IFU accept, prioritized
// exception/branch redirects, misaligned-target trap and accepted-fetch counter.
module pc_gen #(
  parameter int                  BITWIDTH  = 32,
  parameter logic [BITWIDTH-1:0] RST_VALUE = 32'h80000000,
  parameter int                  STEP      = 4
) (
  input  logic     clk,
  input  logic     rst,
  pc_gen_if.master bus
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  // STEP=4 needs word alignment, STEP=2 halfword alignment
  localparam logic [1:0]          ALIGN_MASK = (STEP == 4) ? 2'b11 : 2'b01;
  localparam logic [BITWIDTH-1:0] STEP_INC   = BITWIDTH'(STEP);

  state_t              state_q;
  logic [BITWIDTH-1:0] pc_q;
  logic                pc_valid_q;
  logic                misalign_q;
  logic [BITWIDTH-1:0] bad_target_q;
  logic [BITWIDTH-1:0] fetch_cnt_q;

  logic [BITWIDTH-1:0] imm_ext;
  logic [BITWIDTH-1:0] base_d;
  logic [BITWIDTH-1:0] sum_d;
  logic [BITWIDTH-1:0] tgt_d;
  logic                mis_d;
  logic                fire_d;

  generate
    if (BITWIDTH > 32) begin : g_imm_wide
      assign imm_ext = {{(BITWIDTH-32){bus.imm[31]}}, bus.imm};
    end else begin : g_imm_narrow
      assign imm_ext = bus.imm[BITWIDTH-1:0];
    end
  endgenerate

  always_comb begin
    base_d = bus.redir_sel ? bus.rs1_data : bus.redir_pc;
    sum_d  = base_d + imm_ext;
    tgt_d  = sum_d;
    // jalr target drops bit 0 before the alignment check
    if (bus.redir_sel) tgt_d[0] = 1'b0;
    mis_d  = |(tgt_d[1:0] & ALIGN_MASK);
    fire_d = pc_valid_q & bus.pc_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= BOOT;
      pc_q         <= RST_VALUE;
      pc_valid_q   <= 1'b0;
      misalign_q   <= 1'b0;
      bad_target_q <= '0;
      fetch_cnt_q  <= '0;
    end else begin
      misalign_q <= 1'b0;
      if (fire_d) fetch_cnt_q <= fetch_cnt_q + 1'b1;

      if (bus.exc_valid) begin
        // exception wins over everything and is never alignment-checked
        pc_q       <= bus.exc_target;
        state_q    <= RUN;
        pc_valid_q <= 1'b1;
      end else begin
        unique case (state_q)
          BOOT: begin
            state_q    <= RUN;
            pc_valid_q <= 1'b1;
          end
          RUN: begin
            if (bus.redir_valid) begin
              if (mis_d) begin
                misalign_q   <= 1'b1;
                bad_target_q <= tgt_d;
                state_q      <= HALT;
                pc_valid_q   <= 1'b0;
              end else begin
                pc_q <= tgt_d;
              end
            end else if (fire_d) begin
              pc_q <= pc_q + STEP_INC;
            end
          end
          HALT: begin
            pc_valid_q <= 1'b0;
          end
          default: begin
            state_q    <= BOOT;
            pc_valid_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.pc         = pc_q;
  assign bus.pc_valid   = pc_valid_q;
  assign bus.misalign   = misalign_q;
  assign bus.bad_target = bad_target_q;
  assign bus.fetch_cnt  = fetch_cnt_q;

endmodule
